// File: rtl/route_pkg.sv
// Shared encodings for the maze-routing sequencer: cell values, FSM states and
// the fixed neighbour visiting order used by both wave expansion and backtrace.
package route_pkg;

  localparam logic [7:0] LVL_MAX = 8'd253;
  localparam logic [7:0] PATH    = 8'hFE;
  localparam logic [7:0] BLK     = 8'hFF;

  typedef enum logic [3:0] {
    IDLE,
    CLEAR,
    SEED,
    POP,
    NRD,
    NCHK,
    TRD,
    TCHK,
    FIN
  } state_t;

  localparam logic [1:0] NB_N = 2'd0;
  localparam logic [1:0] NB_S = 2'd1;
  localparam logic [1:0] NB_E = 2'd2;
  localparam logic [1:0] NB_W = 2'd3;

endpackage

// File: rtl/frontier_fifo.sv
// Synchronous FIFO holding {cell, level} records awaiting wave expansion.
// Read data is registered on pop and stays valid until the next pop.
module frontier_fifo #(
  parameter int unsigned W  = 16,
  parameter int unsigned AW = 6
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [W-1:0]  mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // count never exceeds the depth, so its top bit alone means full
  assign full    = count[AW];
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        dout   <= mem[rd_ptr];
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wave_route_ctrl.sv
// Maze-routing sequencer: grid clear, BFS wave expansion from src, backtrace
// from dst. Drives all ram_ctrl controls/addresses and consumes its read data.
module wave_route_ctrl
  import route_pkg::*;
#(
  parameter int unsigned ADDR_LEN = 6,
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned FIFO_AW  = 6
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                clr,
  input  logic                start,
  input  logic [ADDR_LEN+1:0] src_xy,
  input  logic [ADDR_LEN+1:0] dst_xy,
  input  logic [DATA_LEN-1:0] ram_q,
  output logic                clr_ram,
  output logic                BC_mode,
  output logic                wen_cgr,
  output logic                wen_sqg,
  output logic [ADDR_LEN+1:0] XY,
  output logic [ADDR_LEN+1:0] BC_rd_addr,
  output logic [ADDR_LEN+1:0] BC_wr_addr,
  output logic [DATA_LEN-1:0] MLXY,
  output logic [DATA_LEN-1:0] ML1XY,
  output logic                busy,
  output logic                done,
  output logic                fail,
  output logic                overflow,
  output logic [DATA_LEN-1:0] path_len
);

  localparam int unsigned AW = ADDR_LEN + 2;
  localparam int unsigned HW = AW / 2;
  localparam int unsigned FW = AW + DATA_LEN;
  localparam logic [DATA_LEN-1:0] LVL_TOP  = DATA_LEN'(LVL_MAX);
  localparam logic [DATA_LEN-1:0] PATH_VAL = DATA_LEN'(PATH);

  state_t              state, state_n;
  logic [AW-1:0]       src_r, src_n;
  logic [AW-1:0]       dst_r, dst_n;
  logic [AW-1:0]       cur, cur_n;
  logic [DATA_LEN-1:0] lvl, lvl_n;
  logic [1:0]          idx, idx_n;
  logic [AW-1:0]       cnt, cnt_n;
  logic                busy_n, done_n, fail_n, ovf_n;
  logic [DATA_LEN-1:0] len_n;

  logic                flush, push, pop, fifo_full, fifo_empty;
  logic [FW-1:0]       fifo_din, fifo_q;
  logic [AW-1:0]       wcur;
  logic [DATA_LEN-1:0] wlvl;
  logic                cgr, sqg;

  logic [AW-1:0]       base, nb;
  logic [HW-1:0]       bx, by, nx, ny;
  logic                nb_ok, last;

  frontier_fifo #(
    .W  (FW),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .din   (fifo_din),
    .dout  (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The popped FIFO word itself serves as cur/lvl during expansion
  assign wcur = fifo_q[FW-1:DATA_LEN];
  assign wlvl = fifo_q[DATA_LEN-1:0];
  assign base = (state == TRD || state == TCHK) ? cur : wcur;
  assign last = (idx == NB_W);

  always_comb begin
    bx    = base[AW-1:HW];
    by    = base[HW-1:0];
    nx    = bx;
    ny    = by;
    nb_ok = 1'b1;
    case (idx)
      NB_N: begin ny = by - 1'b1; nb_ok = (by != '0); end
      NB_S: begin ny = by + 1'b1; nb_ok = (by != '1); end
      NB_E: begin nx = bx + 1'b1; nb_ok = (bx != '1); end
      default: begin nx = bx - 1'b1; nb_ok = (bx != '0); end
    endcase
    nb = {nx, ny};
  end

  always_comb begin
    state_n    = state;
    src_n      = src_r;
    dst_n      = dst_r;
    cur_n      = cur;
    lvl_n      = lvl;
    idx_n      = idx;
    cnt_n      = cnt;
    done_n     = done;
    fail_n     = fail;
    ovf_n      = overflow;
    len_n      = path_len;
    flush      = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    fifo_din   = '0;
    clr_ram    = 1'b0;
    BC_mode    = 1'b0;
    cgr        = 1'b0;
    sqg        = 1'b0;
    XY         = '0;
    BC_rd_addr = '0;
    BC_wr_addr = '0;
    MLXY       = '0;
    ML1XY      = '0;

    unique case (state)
      IDLE: begin
        if (clr || start) begin
          flush  = 1'b1;
          done_n = 1'b0;
          fail_n = 1'b0;
          ovf_n  = 1'b0;
          len_n  = '0;
          cnt_n  = '0;
          src_n  = src_xy;
          dst_n  = dst_xy;
          state_n = clr ? CLEAR : SEED;
        end
      end
      CLEAR: begin
        clr_ram = 1'b1;
        cgr     = 1'b1;
        XY      = cnt;
        cnt_n   = cnt + 1'b1;
        if (cnt == '1) begin
          state_n = FIN;
          done_n  = 1'b1;
        end
      end
      SEED: begin
        BC_mode  = 1'b1;
        XY       = src_r;
        cgr      = 1'b1;
        push     = 1'b1;
        fifo_din = {src_r, DATA_LEN'(1)};
        if (src_r == dst_r) begin
          state_n = FIN;
          done_n  = 1'b1;
          len_n   = DATA_LEN'(1);
        end else begin
          state_n = POP;
        end
      end
      POP: begin
        if (fifo_empty) begin
          state_n = FIN;
          fail_n  = 1'b1;
        end else begin
          pop     = 1'b1;
          idx_n   = NB_N;
          state_n = NRD;
        end
      end
      NRD: begin
        BC_mode = 1'b1;
        XY      = nb;
        MLXY    = wlvl;
        if (!nb_ok || wlvl == LVL_TOP) begin
          if (last) state_n = POP;
          else idx_n = idx + 1'b1;
        end else begin
          state_n = NCHK;
        end
      end
      NCHK: begin
        BC_mode = 1'b1;
        XY      = nb;
        MLXY    = wlvl;
        if (ram_q == '0 && nb == dst_r) begin
          cgr     = 1'b1;
          cur_n   = nb;
          lvl_n   = wlvl + 1'b1;
          len_n   = wlvl + 1'b1;
          idx_n   = NB_N;
          state_n = TRD;
        end else if (ram_q == '0 && fifo_full) begin
          state_n = FIN;
          fail_n  = 1'b1;
          ovf_n   = 1'b1;
        end else begin
          if (ram_q == '0) begin
            cgr      = 1'b1;
            push     = 1'b1;
            fifo_din = {nb, wlvl + 1'b1};
          end
          if (last) begin
            state_n = POP;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = NRD;
          end
        end
      end
      TRD: begin
        ML1XY = PATH_VAL;
        if (lvl == DATA_LEN'(1)) begin
          BC_wr_addr = cur;
          sqg        = 1'b1;
          state_n    = FIN;
          done_n     = 1'b1;
        end else begin
          BC_rd_addr = nb;
          if (nb_ok) state_n = TCHK;
          else if (last) begin
            state_n = FIN;
            fail_n  = 1'b1;
          end else idx_n = idx + 1'b1;
        end
      end
      TCHK: begin
        ML1XY      = PATH_VAL;
        BC_rd_addr = nb;
        if (ram_q == lvl - 1'b1) begin
          BC_wr_addr = cur;
          sqg        = 1'b1;
          cur_n      = nb;
          lvl_n      = lvl - 1'b1;
          idx_n      = NB_N;
          state_n    = TRD;
        end else if (last) begin
          // no predecessor found: only possible if the RAM was altered mid-run
          state_n = FIN;
          fail_n  = 1'b1;
        end else begin
          idx_n   = idx + 1'b1;
          state_n = TRD;
        end
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE) && (state_n != FIN);
  end

  // Write enables are cut by reset in the same cycle so an abort never writes
  assign wen_cgr = cgr && RST;
  assign wen_sqg = sqg && RST;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state    <= IDLE;
      src_r    <= '0;
      dst_r    <= '0;
      cur      <= '0;
      lvl      <= '0;
      idx      <= '0;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      fail     <= 1'b0;
      overflow <= 1'b0;
      path_len <= '0;
    end else begin
      state    <= state_n;
      src_r    <= src_n;
      dst_r    <= dst_n;
      cur      <= cur_n;
      lvl      <= lvl_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      busy     <= busy_n;
      done     <= done_n;
      fail     <= fail_n;
      overflow <= ovf_n;
      path_len <= len_n;
    end
  end

endmodule
